// File: rtl/wb_spi_master_mc_if.sv
// Wishbone slave-side bus bundle for wb_spi_master_mc.
// The master modport is the bus initiator; the slave modport is the SPI block.
interface wb_spi_master_mc_if;
    logic        cyc_i;
    logic        stb_i;
    logic [1:0]  adr_i;
    logic        we_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        ack_o;
    logic [31:0] dat_o;

    modport master (
        output cyc_i, stb_i, adr_i, we_i, dat_i, sel_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, adr_i, we_i, dat_i, sel_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/wb_spi_master_mc.sv
// Wishbone SPI master: TX/RX FIFOs, software chip selects, programmable SCK
// divider, all four CPOL/CPHA modes, 8- or 32-bit frames chosen by byte select.
// Optional macro WB_SPI_IRQ_EN adds the registered irq_o output and the
// rx_ie/tx_ie enables in CTRL[12]/CTRL[13].
module wb_spi_master_mc #(
    parameter int TX_FIFO_DEPTH = 16,
    parameter int RX_FIFO_DEPTH = 16,
    parameter int NUM_CS        = 4,
    parameter int DIV_W         = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    wb_spi_master_mc_if.slave wb,
    output logic              sck,
    output logic [NUM_CS-1:0] ss_n,
    input  logic              miso,
    output logic              mosi
`ifdef WB_SPI_IRQ_EN
    ,
    output logic              irq_o
`endif
);
    localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
    localparam int RX_AW = $clog2(RX_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LEAD, TRAIL, DONE} state_t;

    state_t            state;
    logic [32:0]       tx_mem [TX_FIFO_DEPTH];
    logic [31:0]       rx_mem [RX_FIFO_DEPTH];
    logic [TX_AW:0]    tx_wp, tx_rp;
    logic [RX_AW:0]    rx_wp, rx_rp;
    logic [DIV_W-1:0]  div_q, div_cnt;
    logic [NUM_CS-1:0] cs_q;
    logic              cpol, cpha, rx_ovf;
    logic [31:0]       tx_sh, rx_sh;
    logic [4:0]        bit_cnt;
    logic [32:0]       tx_head;
    logic [31:0]       load_word;
    logic [31:0]       status_w;
    logic              wb_acc, wr_acc, rd_acc;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic              tx_push, tx_flush, eng_pop;
    logic              rx_push, rx_flush, rx_pop, eng_push, rx_drop;
    logic              busy, busy_eng;
`ifdef WB_SPI_IRQ_EN
    logic              rx_ie, tx_ie;
`endif

    assign wb_acc   = wb.ack_o & wb.cyc_i & wb.stb_i;
    assign wr_acc   = wb_acc & wb.we_i;
    assign rd_acc   = wb_acc & ~wb.we_i;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) && (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) && (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);

    assign tx_push  = wr_acc && (wb.adr_i == 2'd0) && !tx_full;
    assign tx_flush = wr_acc && (wb.adr_i == 2'd1) && wb.dat_i[16];
    assign rx_flush = wr_acc && (wb.adr_i == 2'd1) && wb.dat_i[17];
    assign rx_pop   = rd_acc && (wb.adr_i == 2'd0) && !rx_empty;

    // The engine never starts a frame while RX is full, so DONE normally finds room.
    assign eng_pop  = (state == IDLE) && !tx_empty && !rx_full;
    assign eng_push = (state == DONE);
    assign rx_push  = eng_push && !rx_flush && (!rx_full || rx_pop);
    assign rx_drop  = eng_push && !rx_flush && rx_full && !rx_pop;

    assign busy_eng = (state != IDLE);
    assign busy     = busy_eng || !tx_empty;

    assign tx_head   = tx_mem[tx_rp[TX_AW-1:0]];
    assign load_word = tx_head[32] ? tx_head[31:0] : {tx_head[7:0], 24'h0};
    assign ss_n      = ~cs_q;

`ifdef WB_SPI_IRQ_EN
    assign status_w = {18'h0, tx_ie, rx_ie, 1'b0, rx_ovf, cpha, cpol, 3'b0,
                       rx_empty, rx_full, tx_empty, tx_full, busy};
`else
    assign status_w = {21'h0, rx_ovf, cpha, cpol, 3'b0,
                       rx_empty, rx_full, tx_empty, tx_full, busy};
`endif

    // Single-cycle ack that can never be asserted on two consecutive cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wb.ack_o <= 1'b0;
        else         wb.ack_o <= wb.stb_i & wb.cyc_i & ~wb.ack_o;
    end

    // Read mux is only driven during the ack cycle, zero otherwise.
    always_comb begin
        wb.dat_o = 32'h0;
        if (wb.ack_o && !wb.we_i) begin
            case (wb.adr_i)
                2'd0:    wb.dat_o = rx_empty ? 32'h0 : rx_mem[rx_rp[RX_AW-1:0]];
                2'd1:    wb.dat_o = status_w;
                2'd2:    wb.dat_o = 32'(div_q);
                default: wb.dat_o = 32'(cs_q);
            endcase
        end
    end

    // TX FIFO storage; 8-bit frames keep their byte in the low bits until load.
    always_ff @(posedge clk_i) begin
        if (tx_push)
            tx_mem[tx_wp[TX_AW-1:0]] <= {(wb.sel_i == 4'b1111),
                (wb.sel_i == 4'b1111) ? wb.dat_i : {24'h0, wb.dat_i[7:0]}};
    end

    // TX pointers; a flush discards every queued entry but not the frame in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else if (tx_flush) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (eng_pop) tx_rp <= tx_rp + 1'b1;
        end
    end

    // RX FIFO storage for completed frames.
    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= rx_sh;
    end

    // RX pointers; a flush beats a simultaneous frame push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else if (rx_flush) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end

    // Control, divider and chip-select registers; mode bits are frozen while busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cpol   <= 1'b0;
            cpha   <= 1'b0;
            rx_ovf <= 1'b0;
            div_q  <= '0;
            cs_q   <= '0;
`ifdef WB_SPI_IRQ_EN
            rx_ie  <= 1'b0;
            tx_ie  <= 1'b0;
`endif
        end else begin
            if (wr_acc) begin
                case (wb.adr_i)
                    2'd1: begin
                        if (!busy) begin
                            cpol <= wb.dat_i[8];
                            cpha <= wb.dat_i[9];
                        end
                        if (wb.dat_i[10]) rx_ovf <= 1'b0;
`ifdef WB_SPI_IRQ_EN
                        rx_ie <= wb.dat_i[12];
                        tx_ie <= wb.dat_i[13];
`endif
                    end
                    2'd2:    div_q <= wb.dat_i[DIV_W-1:0];
                    2'd3:    cs_q  <= wb.dat_i[NUM_CS-1:0];
                    default: ;
                endcase
            end
            if (rx_drop) rx_ovf <= 1'b1;
        end
    end

`ifdef WB_SPI_IRQ_EN
    // Level interrupt: RX data waiting, or TX drained with the engine idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_o <= 1'b0;
        else         irq_o <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~busy_eng);
    end
`endif

    // Shift engine: each half-period lasts DIV+1 clocks; divider is re-read every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sck     <= cpol;
                    div_cnt <= '0;
                    if (eng_pop) begin
                        bit_cnt <= tx_head[32] ? 5'd31 : 5'd7;
                        rx_sh   <= '0;
                        if (cpha) begin
                            tx_sh <= load_word;
                        end else begin
                            tx_sh <= {load_word[30:0], 1'b0};
                            mosi  <= load_word[31];
                        end
                        state <= LEAD;
                    end
                end
                LEAD: begin
                    if (div_cnt >= div_q) begin
                        div_cnt <= '0;
                        sck     <= ~cpol;
                        if (!cpha) begin
                            rx_sh <= {rx_sh[30:0], miso};
                        end else begin
                            mosi  <= tx_sh[31];
                            tx_sh <= {tx_sh[30:0], 1'b0};
                        end
                        state <= TRAIL;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (div_cnt >= div_q) begin
                        div_cnt <= '0;
                        sck     <= cpol;
                        if (cpha) begin
                            rx_sh <= {rx_sh[30:0], miso};
                        end else if (bit_cnt != 5'd0) begin
                            mosi  <= tx_sh[31];
                            tx_sh <= {tx_sh[30:0], 1'b0};
                        end
                        if (bit_cnt == 5'd0) begin
                            state <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            state   <= LEAD;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
